// File: rtl/dispatch_router_pkg.sv
// dispatch_router_pkg: types shared between warp_schedular and dispatch_router.
//   dispatch_req_t  103-bit scheduler dispatch request
//   issue_pkt_t     100-bit payload delivered to an execution unit
//   UNIT_*          positions of the one-hot unit type bits inside dispatch_req_t
//   KIANA_SP_ERR_*  bit positions inside the router's sticky error register
`ifndef KIANA_SP_ERR_ROUTER_BAD_TYPE
`define KIANA_SP_ERR_ROUTER_BAD_TYPE 0
`endif
`ifndef KIANA_SP_ERR_ROUTER_OVERFLOW
`define KIANA_SP_ERR_ROUTER_OVERFLOW 1
`endif

package dispatch_router_pkg;

   localparam int unsigned REQ_W    = 103;
   localparam int unsigned PKT_W    = 100;
   localparam int unsigned UNIT_ALU = 2;
   localparam int unsigned UNIT_LSU = 1;
   localparam int unsigned UNIT_SP  = 0;

   typedef struct packed {
      logic [4:0]  warp;
      logic [62:0] instr;
      logic [31:0] pred;
      logic        alu;
      logic        lsu;
      logic        sp;
   } dispatch_req_t;

   typedef struct packed {
      logic [4:0]  warp;
      logic [62:0] instr;
      logic [31:0] pred;
   } issue_pkt_t;

   // Strip the routing bits; the unit does not need to know its own type.
   function automatic issue_pkt_t to_pkt(input dispatch_req_t req);
      issue_pkt_t pkt;
      pkt.warp  = req.warp;
      pkt.instr = req.instr;
      pkt.pred  = req.pred;
      return pkt;
   endfunction

endpackage

// File: rtl/dispatch_router_issue_queue.sv
// issue_queue: synchronous FIFO feeding one execution unit.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored when full)
//   push_data    entry to enqueue
//   pop          consumer ready; an entry leaves when pop and not empty
//   head_data    registered head entry; holds its last value when empty, 0 after reset
//   occ          number of stored entries
//   full, empty  occupancy flags
module issue_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 100,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] occ,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             push_en, pop_en;

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (occ_q == CNT_W'(DEPTH));
   assign empty   = (occ_q == '0);
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;

   always_comb begin
      rd_d   = pop_en  ? next_ptr(rd_q) : rd_q;
      wr_d   = push_en ? next_ptr(wr_q) : wr_q;
      occ_d  = occ_q;
      head_d = head_q;
      unique case ({push_en, pop_en})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase
      // The next head is either already stored or is being written this cycle
      // (queue empty, or a single entry being replaced by push+pop).
      if (occ_d != '0) begin
         head_d = (push_en && (wr_q == rd_d)) ? push_data : mem[rd_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q   <= '0;
         wr_q   <= '0;
         occ_q  <= '0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         occ_q  <= occ_d;
         head_q <= head_d;
      end
   end

   assign head_data = head_q;
   assign occ       = occ_q;

endmodule

// File: rtl/dispatch_router.sv
// dispatch_router: decodes scheduler dispatch requests into per-unit issue queues.
//   clk, rst_n         clock, asynchronous active-low reset
//   s_tvalid_req/s_tready_req/s_req_data   request stream from the scheduler
//   sched_ready_{alu,lsu,sp}               per-unit space hints for scheduler arbitration
//   m_{alu,lsu,sp}_{tvalid,tready,tdata}   issue streams to the execution units
//   occ_{alu,lsu,sp}   queue occupancies
//   err_clr, err       sticky error flags and their synchronous clear
module dispatch_router
   import dispatch_router_pkg::*;
#(
   parameter int unsigned UNIT_DEPTH = 4,
   parameter int unsigned CNT_W      = $clog2(UNIT_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_tvalid_req,
   output logic               s_tready_req,
   input  logic [REQ_W-1:0]   s_req_data,
   output logic               sched_ready_alu,
   output logic               sched_ready_lsu,
   output logic               sched_ready_sp,
   output logic               m_alu_tvalid,
   input  logic               m_alu_tready,
   output logic [PKT_W-1:0]   m_alu_tdata,
   output logic               m_lsu_tvalid,
   input  logic               m_lsu_tready,
   output logic [PKT_W-1:0]   m_lsu_tdata,
   output logic               m_sp_tvalid,
   input  logic               m_sp_tready,
   output logic [PKT_W-1:0]   m_sp_tdata,
   output logic [CNT_W-1:0]   occ_alu,
   output logic [CNT_W-1:0]   occ_lsu,
   output logic [CNT_W-1:0]   occ_sp,
   input  logic               err_clr,
   output logic [31:0]        err
);

   dispatch_req_t req;
   issue_pkt_t    pkt;
   logic [2:0]    type_bits;
   logic          accept;
   logic          sel_alu, sel_lsu, sel_sp;
   logic          full_alu, full_lsu, full_sp;
   logic          empty_alu, empty_lsu, empty_sp;
   logic          bad_type, overflow;
   logic [1:0]    err_q, err_d, err_set;

   assign req       = dispatch_req_t'(s_req_data);
   assign pkt       = to_pkt(req);
   assign type_bits = 3'({req.alu, req.lsu, req.sp});

   assign s_tready_req = ~(full_alu | full_lsu | full_sp);
   assign accept       = s_tvalid_req & s_tready_req;

   assign sel_alu  = accept && (type_bits == 3'(1 << UNIT_ALU));
   assign sel_lsu  = accept && (type_bits == 3'(1 << UNIT_LSU));
   assign sel_sp   = accept && (type_bits == 3'(1 << UNIT_SP));
   assign bad_type = accept & ~(sel_alu | sel_lsu | sel_sp);
   // Unreachable while s_tready_req gates on full; kept as a safety net.
   assign overflow = (sel_alu & full_alu) | (sel_lsu & full_lsu) | (sel_sp & full_sp);

   // Reserve one slot for the request the scheduler already has in flight.
   assign sched_ready_alu = (occ_alu <= CNT_W'(UNIT_DEPTH - 2));
   assign sched_ready_lsu = (occ_lsu <= CNT_W'(UNIT_DEPTH - 2));
   assign sched_ready_sp  = (occ_sp  <= CNT_W'(UNIT_DEPTH - 2));

   assign m_alu_tvalid = ~empty_alu;
   assign m_lsu_tvalid = ~empty_lsu;
   assign m_sp_tvalid  = ~empty_sp;

   issue_queue #(.DEPTH(UNIT_DEPTH), .WIDTH(PKT_W), .CNT_W(CNT_W)) u_alu_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (sel_alu),
      .push_data (pkt),
      .pop       (m_alu_tready),
      .head_data (m_alu_tdata),
      .occ       (occ_alu),
      .full      (full_alu),
      .empty     (empty_alu)
   );

   issue_queue #(.DEPTH(UNIT_DEPTH), .WIDTH(PKT_W), .CNT_W(CNT_W)) u_lsu_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (sel_lsu),
      .push_data (pkt),
      .pop       (m_lsu_tready),
      .head_data (m_lsu_tdata),
      .occ       (occ_lsu),
      .full      (full_lsu),
      .empty     (empty_lsu)
   );

   issue_queue #(.DEPTH(UNIT_DEPTH), .WIDTH(PKT_W), .CNT_W(CNT_W)) u_sp_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (sel_sp),
      .push_data (pkt),
      .pop       (m_sp_tready),
      .head_data (m_sp_tdata),
      .occ       (occ_sp),
      .full      (full_sp),
      .empty     (empty_sp)
   );

   always_comb begin
      err_set = '0;
      err_set[`KIANA_SP_ERR_ROUTER_BAD_TYPE] = bad_type;
      err_set[`KIANA_SP_ERR_ROUTER_OVERFLOW] = overflow;
      // Clear first, then OR in new flags so a same-cycle error survives the clear.
      err_d = (err_clr ? 2'b00 : err_q) | err_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = {30'b0, err_q};

endmodule

// File: tb/tb_dispatch_router.sv
module tb_dispatch_router;
   import dispatch_router_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_tvalid_req;
   logic              s_tready_req;
   logic [102:0]      s_req_data;
   logic              sched_ready_alu, sched_ready_lsu, sched_ready_sp;
   logic              m_alu_tvalid, m_lsu_tvalid, m_sp_tvalid;
   logic [99:0]       m_alu_tdata, m_lsu_tdata, m_sp_tdata;
   logic [CW-1:0]     occ_alu, occ_lsu, occ_sp;
   logic              err_clr;
   logic [31:0]       err;
   logic              rdy [3];   // 0 = ALU, 1 = LSU, 2 = special

   dispatch_router #(.UNIT_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_tvalid_req    (s_tvalid_req),
      .s_tready_req    (s_tready_req),
      .s_req_data      (s_req_data),
      .sched_ready_alu (sched_ready_alu),
      .sched_ready_lsu (sched_ready_lsu),
      .sched_ready_sp  (sched_ready_sp),
      .m_alu_tvalid    (m_alu_tvalid),
      .m_alu_tready    (rdy[0]),
      .m_alu_tdata     (m_alu_tdata),
      .m_lsu_tvalid    (m_lsu_tvalid),
      .m_lsu_tready    (rdy[1]),
      .m_lsu_tdata     (m_lsu_tdata),
      .m_sp_tvalid     (m_sp_tvalid),
      .m_sp_tready     (rdy[2]),
      .m_sp_tdata      (m_sp_tdata),
      .occ_alu         (occ_alu),
      .occ_lsu         (occ_lsu),
      .occ_sp          (occ_sp),
      .err_clr         (err_clr),
      .err             (err)
   );

   always #5 clk = ~clk;

   logic          dv  [3];
   logic [99:0]   dd  [3];
   logic [CW-1:0] doc [3];
   logic          dsr [3];
   assign dv[0] = m_alu_tvalid;  assign dv[1] = m_lsu_tvalid;  assign dv[2] = m_sp_tvalid;
   assign dd[0] = m_alu_tdata;   assign dd[1] = m_lsu_tdata;   assign dd[2] = m_sp_tdata;
   assign doc[0] = occ_alu;      assign doc[1] = occ_lsu;      assign doc[2] = occ_sp;
   assign dsr[0] = sched_ready_alu; assign dsr[1] = sched_ready_lsu;
   assign dsr[2] = sched_ready_sp;

   // Reference model: one queue of expected payloads per unit.
   logic [99:0] q [3][$];
   logic [99:0] last [3];
   logic [1:0]  err_m;
   bit          model_rdy;
   bit          stim_done;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 3; u++) begin
         q[u].delete();
         last[u] = '0;
      end
      err_m = '0;
   endtask

   // Scoreboard push: the accepted request is routed by its type bits.
   always @(posedge clk) begin
      if (rst_n) begin
         if (err_clr) err_m = 2'b00;
         if (s_tvalid_req && model_rdy) begin
            case (s_req_data[2:0])
               3'b100:  q[0].push_back(s_req_data[102:3]);
               3'b010:  q[1].push_back(s_req_data[102:3]);
               3'b001:  q[2].push_back(s_req_data[102:3]);
               default: err_m[0] = 1'b1;
            endcase
         end
      end
   end

   // Monitor: compare outputs mid-cycle, then retire entries the unit takes.
   always @(negedge clk) begin
      if (rst_n) begin
         model_rdy = 1'b1;
         for (int u = 0; u < 3; u++) if (q[u].size() >= DEPTH) model_rdy = 1'b0;
         chk("s_tready_req", 128'(s_tready_req), 128'(model_rdy));
         chk("err", 128'(err), 128'(err_m));
         for (int u = 0; u < 3; u++) begin
            chk($sformatf("occ[%0d]", u), 128'(doc[u]), 128'(q[u].size()));
            chk($sformatf("sched_ready[%0d]", u), 128'(dsr[u]),
                128'(q[u].size() <= DEPTH - 2));
            chk($sformatf("tvalid[%0d]", u), 128'(dv[u]), 128'(q[u].size() != 0));
            if (q[u].size() != 0) begin
               chk($sformatf("tdata[%0d]", u), 128'(dd[u]), 128'(q[u][0]));
               if (rdy[u]) last[u] = q[u].pop_front();
            end else begin
               chk($sformatf("tdata_hold[%0d]", u), 128'(dd[u]), 128'(last[u]));
            end
         end
      end
   end

   // Drive one request, holding it until the model says it is taken.
   task automatic send(input logic [2:0] ty, input logic [4:0] warp);
      logic [102:0] d;
      bit           taken;
      d[31:0]   = $urandom;
      d[63:32]  = $urandom;
      d[95:64]  = $urandom;
      d[102:96] = 7'($urandom);
      d[102:98] = warp;
      d[2:0]    = ty;
      s_req_data   = d;
      s_tvalid_req = 1'b1;
      taken = 1'b0;
      for (int i = 0; i < 300 && !taken; i++) begin
         @(posedge clk);
         if (model_rdy) taken = 1'b1;
      end
      #1;
      if (!taken) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got not-accepted expected accepted at %0t", $time);
         s_tvalid_req = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      s_tvalid_req = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [2:0] rand_type();
      int r;
      r = $urandom_range(0, 7);
      if (r == 7) return 3'($urandom);
      return 3'(3'b001 << (r % 3));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; s_tvalid_req = 1'b0; s_req_data = '0; err_clr = 1'b0;
      for (int u = 0; u < 3; u++) rdy[u] = 1'b0;
      model_reset();
      stim_done = 1'b0;
      #1;
      chk("rst_valid", 128'({m_alu_tvalid, m_lsu_tvalid, m_sp_tvalid}), 128'(0));
      chk("rst_occ", 128'({occ_alu, occ_lsu, occ_sp}), 128'(0));
      chk("rst_data", 128'(m_alu_tdata | m_lsu_tdata | m_sp_tdata), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // T1: single ALU request, warp 5, unit always ready
      rdy[0] = 1'b1;
      send(3'b100, 5'd5);
      idle(3);

      // T2: LSU stalled, fill to full
      rdy[1] = 1'b0;
      repeat (3) send(3'b010, 5'($urandom));
      s_tvalid_req = 1'b0;
      @(negedge clk);
      chk("t2_sched_ready_lsu", 128'(sched_ready_lsu), 128'(0));
      chk("t2_tready_after3", 128'(s_tready_req), 128'(1));
      @(posedge clk); #1;
      send(3'b010, 5'($urandom));
      s_tvalid_req = 1'b0;
      @(negedge clk);
      chk("t2_tready_full", 128'(s_tready_req), 128'(0));
      @(posedge clk); #1;

      // T3: ALU and special blocked until LSU drains one entry
      rdy[2] = 1'b1;
      fork
         begin
            send(3'b100, 5'($urandom));
            send(3'b001, 5'($urandom));
            s_tvalid_req = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1 rdy[1] = 1'b1;
            @(posedge clk);
            #1 rdy[1] = 1'b0;
         end
      join
      idle(3);
      rdy[1] = 1'b1;
      idle(6);

      // T4: bad types set err[0]; err_clr clears it
      send(3'b011, 5'd1);
      send(3'b000, 5'd2);
      idle(1);
      @(negedge clk);
      chk("t4_err_set", 128'(err), 128'h1);
      @(posedge clk); #1;
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      @(negedge clk);
      chk("t4_err_clr", 128'(err), 128'h0);
      @(posedge clk); #1;

      // T5: special queue held at occupancy 1 with push+pop every cycle
      rdy[2] = 1'b0;
      send(3'b001, 5'($urandom));
      rdy[2] = 1'b1;
      repeat (10) send(3'b001, 5'($urandom));
      idle(4);

      // Randomised traffic with random back-pressure and clears
      fork
         begin
            while (!stim_done) begin
               @(posedge clk);
               #1;
               for (int u = 0; u < 3; u++) rdy[u] = ($urandom_range(0, 3) != 0);
               err_clr = ($urandom_range(0, 15) == 0);
            end
         end
         begin
            repeat (300) begin
               if ($urandom_range(0, 2) != 0) send(rand_type(), 5'($urandom));
               else idle(1);
            end
            s_tvalid_req = 1'b0;
            stim_done = 1'b1;
         end
      join
      err_clr = 1'b0;
      for (int u = 0; u < 3; u++) rdy[u] = 1'b1;
      idle(8);

      // T6: reset with all queues partially filled and an error pending
      for (int u = 0; u < 3; u++) rdy[u] = 1'b0;
      send(3'b100, 5'd1);
      send(3'b010, 5'd2);
      send(3'b001, 5'd3);
      send(3'b100, 5'd4);
      send(3'b111, 5'd5);
      s_tvalid_req = 1'b0;
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_valid", 128'({m_alu_tvalid, m_lsu_tvalid, m_sp_tvalid}), 128'(0));
      chk("t6_occ", 128'({occ_alu, occ_lsu, occ_sp}), 128'(0));
      chk("t6_err", 128'(err), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int u = 0; u < 3; u++) rdy[u] = 1'b1;
      repeat (20) send(rand_type(), 5'($urandom));
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
